// File: rtl/sipo_deser.sv
`default_nettype none
// ============================================================================
// Module   : sipo_deser
// Brief    : WIDTH-bit framed serial-to-parallel deserialiser with a holding
//            register, valid/ready output handshake and overrun pulse.
// Revision : 1.0
// ============================================================================
module sipo_deser #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin,
  input  logic             sin_valid,
  input  logic             frame_start,
  output logic [WIDTH-1:0] po,
  output logic             po_valid,
  input  logic             po_ready,
  output logic             overrun
);

  localparam int               c_cnt_w = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(WIDTH - 1);
  localparam logic [c_cnt_w-1:0] c_one   = c_cnt_w'(1);

  logic [WIDTH-1:0]   r_sr;
  logic [c_cnt_w-1:0] r_cnt;
  logic [WIDTH-1:0]   r_po;
  logic               r_po_valid;
  logic               r_overrun;

  logic [WIDTH-1:0]   w_sr_next;
  logic [c_cnt_w-1:0] w_cnt_base;
  logic               w_complete;
  logic               w_take;
  logic               w_load;

  generate
    if (MSB_FIRST) begin : g_msb_first
      assign w_sr_next = {r_sr[WIDTH-2:0], sin};
    end else begin : g_lsb_first
      assign w_sr_next = {sin, r_sr[WIDTH-1:1]};
    end
  endgenerate

  // A resync restarts the count before the current bit is accepted, so a
  // bit arriving with frame_start can never complete a word.
  assign w_cnt_base = frame_start ? '0 : r_cnt;
  assign w_complete = sin_valid && (w_cnt_base == c_last);
  assign w_take     = r_po_valid && po_ready;
  assign w_load     = w_complete && (!r_po_valid || po_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sr  <= '0;
      r_cnt <= '0;
    end else if (sin_valid) begin
      r_sr  <= w_sr_next;
      r_cnt <= w_complete ? '0 : (w_cnt_base + c_one);
    end else if (frame_start) begin
      r_cnt <= '0;
    end
  end

  // Holding register: a completed word may replace the held one only in the
  // same cycle the consumer takes it; otherwise the new word is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_po       <= '0;
      r_po_valid <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_overrun <= w_complete && r_po_valid && !po_ready;
      if (w_load) begin
        r_po       <= w_sr_next;
        r_po_valid <= 1'b1;
      end else if (w_take) begin
        r_po_valid <= 1'b0;
      end
    end
  end

  assign po       = r_po;
  assign po_valid = r_po_valid;
  assign overrun  = r_overrun;

endmodule
`default_nettype wire

// File: doc/sipo_deser.md
# sipo_deser

Parametrised serial-in/parallel-out deserialiser with bit-framing, selectable bit order and a registered output word with valid/ready handshake. It extends the fixed 4-bit shift chain into a WIDTH-bit collector that accepts qualified serial bits, frames them into words with a bit counter, and double-buffers completed words so collection continues while the downstream consumer stalls. It sits between a serial receive path and a parallel word-oriented consumer.

## Interface
Parameters:
- WIDTH, 8, word width in bits; legal range 2..32.
- MSB_FIRST, 1, bit order. 1: the first received bit lands in po[WIDTH-1]. 0: the first received bit lands in po[0].

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- sin  input  1  serial data bit, sampled only when sin_valid=1.
- sin_valid  input  1  qualifies sin for the current cycle.
- frame_start  input  1  synchronous word resync; discards any partial word.
- po  output  WIDTH  completed parallel word (holding register).
- po_valid  output  1  po holds an unconsumed word.
- po_ready  input  1  consumer accepts po when po_valid=1 and po_ready=1.
- overrun  output  1  one-cycle pulse: a completed word was dropped.

## Operation
- State: shift register sr[WIDTH-1:0], bit counter cnt (ceil(log2 WIDTH) bits, range 0..WIDTH-1), holding register po, flag po_valid, pulse register overrun.
- Reset (async, rst=1): sr=0, cnt=0, po=0, po_valid=0, overrun=0. Any partial word is lost.
- Shift on sin_valid=1:
  - MSB_FIRST=1: sr <= {sr[WIDTH-2:0], sin}.
  - MSB_FIRST=0: sr <= {sin, sr[WIDTH-1:1]}.
  - cnt increments; on cnt==WIDTH-1 the word completes and cnt wraps to 0.
- sin_valid=0: sr and cnt hold.
- frame_start=1: cnt forced to 0 before the accept. If sin_valid=1 in the same cycle, that bit is counted as bit 0 of a new word (cnt becomes 1). Partial sr contents are not cleared but are overwritten by subsequent shifts. Has no effect on po, po_valid or overrun.
- Word completion (the accepted bit is the WIDTH-th bit): the completed word is the post-shift value of sr.
  - po_valid=0, or po_valid=1 with po_ready=1 in the same cycle: po <= completed word, po_valid <= 1.
  - po_valid=1 and po_ready=0: the word is dropped, po and po_valid are unchanged, overrun <= 1 for one cycle.
- Handshake: po_valid=1 and po_ready=1 with no completion in that cycle gives po_valid <= 0. po holds its last value (not cleared).
- While po_valid=1, po is stable until the handshake.
- po_ready is ignored while po_valid=0.
- overrun is 0 in every cycle not described above.

## Timing
- Latency: po and po_valid update on the same rising edge that samples the WIDTH-th bit; both are visible in the following cycle.
- Maximum throughput: one word per WIDTH accepted bits, with no bubble when the consumer holds po_ready=1.
- Double buffering: a stalled consumer gives WIDTH bit-times of slack before an overrun occurs.
- All outputs are registered; no combinational path from any input to any output.
- An asynchronous rst mid-word clears everything immediately. The first sin_valid bit after rst deasserts is bit 0.
- Simultaneous events in one cycle:
  - Completion with handshake: load the new word, po_valid stays 1.
  - frame_start with completion: frame_start wins, so no completion occurs and the bit becomes bit 0.

## Test plan
- WIDTH=8, MSB_FIRST=1, po_ready=1: send bits 1,0,1,0,0,1,0,1 on consecutive cycles -> po=8'hA5 with po_valid=1 for exactly one cycle, starting the cycle after the 8th bit.
- WIDTH=8, MSB_FIRST=0: same bit stream -> po=8'hA5 bit-reversed, i.e. 8'hA5 (palindrome). Then send 1,1,1,1,0,0,0,0 -> po=8'h0F.
- Gapped input: sin_valid toggled 1/0 for 8'h3C MSB-first -> po=8'h3C after 8 accepted bits; cnt does not advance on idle cycles.
- Stall: po_ready=0, send 8'h11 then 8'h22 -> po stays 8'h11 with po_valid=1, and overrun pulses once on completion of 8'h22. Then assert po_ready for one cycle -> po_valid=0.
- Resync: send 3 bits, then frame_start=1 together with the first bit of 8'hC3 -> po=8'hC3 after 8 bits total from the resync. Also assert rst after 5 bits of a word -> all outputs 0 immediately; the next 8 bits form a clean word.
